alu_n_bit: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_comb.sv | 38 +++
 rtl/alu_n_bit.sv | 35 +++
 tb/tb_alu_n_bit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU family.
//   opcode_t : 3-bit opcode type
//   OP_*     : opcode constants; all eight encodings are defined operations
package alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD = 3'b000;
  localparam opcode_t OP_SUB = 3'b001;
  localparam opcode_t OP_AND = 3'b010;
  localparam opcode_t OP_OR  = 3'b011;
  localparam opcode_t OP_XOR = 3'b100;
  localparam opcode_t OP_NOT = 3'b101;
  localparam opcode_t OP_SHL = 3'b110;
  localparam opcode_t OP_SHR = 3'b111;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU datapath. It is reusable by an unregistered variant.
// Ports:
//   a, b   : WIDTH-bit unsigned operands
//   sel    : opcode (alu_pkg::opcode_t)
//   result : WIDTH+1 bits. The MSB holds the carry, the borrow, or the bit shifted out.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          sel,
  output logic [WIDTH:0]   result
);

  // Zero-extend the operands so that ADD and SUB produce the carry or borrow in the MSB.
  // SUB wraps mod 2^(WIDTH+1). For that reason its MSB is set exactly when a < b.
  logic [WIDTH:0] ax, bx;
  assign ax = {1'b0, a};
  assign bx = {1'b0, b};

  always_comb begin
    result = '0;
    unique case (sel)
      OP_ADD: result = ax + bx;
      OP_SUB: result = ax - bx;
      OP_AND: result = {1'b0, a & b};
      OP_OR:  result = {1'b0, a | b};
      OP_XOR: result = {1'b0, a ^ b};
      OP_NOT: result = {1'b0, ~a};
      OP_SHL: result = {a, 1'b0};
      OP_SHR: result = {2'b00, a[WIDTH-1:1]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_n_bit.sv
// ALU with a registered result. A new operation is accepted on every clock, and the latency is 1 cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset. It forces out to 0 and has priority over the operation.
//   a, b : WIDTH-bit unsigned operands
//   sel  : 3-bit opcode
//   out  : WIDTH+1-bit registered result. Bit WIDTH holds the carry, the borrow, or the bit shifted out.
module alu_n_bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH:0]   out
);

  logic [WIDTH:0] result;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (a),
    .b      (b),
    .sel    (opcode_t'(sel)),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= result;
  end

endmodule

// File: tb/tb_alu_n_bit.sv
module tb_alu_n_bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [2:0]   sel = '0;
  logic [W:0]   out;

  int nvec = 0;
  int nerr = 0;

  alu_n_bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sel (sel),
    .out (out)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic, reduced mod 2^(W+1).
  function automatic logic [W:0] ref_f(input int ia, input int ib, input int s);
    int m, r;
    m = 1 << (W + 1);
    case (s)
      0:       r = (ia + ib) % m;
      1:       r = (ia - ib + m) % m;
      2:       r = ia & ib;
      3:       r = ia | ib;
      4:       r = ia ^ ib;
      5:       r = (~ia) & ((1 << W) - 1);
      6:       r = (ia * 2) % m;
      default: r = ia / 2;
    endcase
    return r[W:0];
  endfunction

  // Drive one cycle of inputs, then check out just after the edge that captured them.
  task automatic step(input logic r, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [2:0] s, input logic [W:0] exp, input string name);
    rst = r; a = ia; b = ib; sel = s;
    @(posedge clk);
    #1;
    nvec++;
    if (out !== exp) begin
      nerr++;
      $display("FAIL %s: rst=%0b a=%h b=%h sel=%0d out=%h expected=%h", name, r, ia, ib, s, out, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [W:0]   exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Directed table. The vectors are applied back to back, one per cycle.
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 3'd0, 9'h000, "reset0"});
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 3'd0, 9'h000, "reset1"});
    vecs.push_back('{1'b0, 8'hFF, 8'hFF, 3'd0, 9'h1FE, "add_max_max"});
    vecs.push_back('{1'b0, 8'hFF, 8'hFF, 3'd0, 9'h1FE, "add_hold"});
    vecs.push_back('{1'b0, 8'hFF, 8'h01, 3'd0, 9'h100, "add_carry"});
    vecs.push_back('{1'b0, 8'h12, 8'h34, 3'd0, 9'h046, "add_plain"});
    vecs.push_back('{1'b0, 8'h05, 8'h03, 3'd1, 9'h002, "sub_plain"});
    vecs.push_back('{1'b0, 8'h03, 8'h05, 3'd1, 9'h1FE, "sub_borrow"});
    vecs.push_back('{1'b0, 8'h00, 8'h01, 3'd1, 9'h1FF, "sub_0_1"});
    vecs.push_back('{1'b0, 8'hF0, 8'h3C, 3'd2, 9'h030, "and"});
    vecs.push_back('{1'b0, 8'hF0, 8'h3C, 3'd3, 9'h0FC, "or"});
    vecs.push_back('{1'b0, 8'hF0, 8'h3C, 3'd4, 9'h0CC, "xor"});
    vecs.push_back('{1'b0, 8'hF0, 8'h3C, 3'd5, 9'h00F, "not"});
    vecs.push_back('{1'b0, 8'h81, 8'h00, 3'd6, 9'h102, "shl"});
    vecs.push_back('{1'b0, 8'h81, 8'h00, 3'd7, 9'h040, "shr"});
    vecs.push_back('{1'b1, 8'h81, 8'h00, 3'd6, 9'h000, "rst_prio"});
    vecs.push_back('{1'b0, 8'h81, 8'h00, 3'd6, 9'h102, "rst_release"});

    @(negedge clk);
    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp, vecs[i].name);

    // Strided sweep. a covers every value, b takes 16 values, and all opcodes are applied.
    // The inputs change every cycle. A single reset cycle is inserted partway through.
    begin
      int n;
      n = 0;
      for (int ia = 0; ia < 256; ia++)
        for (int ib = 0; ib < 256; ib += 17)
          for (int s = 0; s < 8; s++) begin
            n++;
            if (n == 10000)
              step(1'b1, W'(ia), W'(ib), 3'(s), '0, "sweep_rst");
            else
              step(1'b0, W'(ia), W'(ib), 3'(s), ref_f(ia, ib, s), "sweep");
          end
    end

    // Random stimulus. Reset is applied occasionally.
    for (int k = 0; k < 4000; k++) begin
      int ra, rb, rs;
      logic rr;
      ra = int'($urandom_range(255));
      rb = int'($urandom_range(255));
      rs = int'($urandom_range(7));
      rr = ($urandom_range(63) == 0);
      step(rr, W'(ra), W'(rb), 3'(rs), rr ? '0 : ref_f(ra, rb, rs), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
